mic3_sample_fifo: RTL and testbench
===================================

MIC3_SAMPLE_FIFO -- requirements
Module: mic3_sample_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16: FIFO depth in samples; power of two, 4..256.
REQ-002 The block SHALL have parameter SAMPLE_DIV, default 2268: clk cycles between read requests (100 MHz / 2268 = 44.09 kHz); legal range 32..65535.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port enable, input, 1 bit: run the periodic read-request generator.
REQ-006 The block SHALL have port read, output, 1 bit: one-cycle request pulse to the MIC3 SPI interface.
REQ-007 The block SHALL have port audio_in, input, 12 bits: sample from the MIC3 interface.
REQ-008 The block SHALL have port new_data, input, 1 bit: one-cycle pulse; audio_in is valid in that cycle.
REQ-009 The block SHALL have port m_data, output, 12 bits: oldest stored sample.
REQ-010 The block SHALL have port m_valid, output, 1 bit: the FIFO is non-empty.
REQ-011 The block SHALL have port m_ready, input, 1 bit: consumer accepts m_data.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: occupancy, 0..DEPTH.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky flag, a sample arrived while the FIFO was full.
REQ-014 The block SHALL have port clear_ovf, input, 1 bit: synchronous clear of overflow.

Function
REQ-015 Divider: while enable=1 the counter SHALL count 0..SAMPLE_DIV-1 and wrap; read=1 for exactly the cycle in which counter==SAMPLE_DIV-1.
REQ-016 enable=0 SHALL force the counter to 0 and read to 0; the first read after enable rises occurs SAMPLE_DIV cycles later.
REQ-017 Push: a rising edge with new_data=1 SHALL write audio_in at wr_ptr; samples are accepted regardless of enable.
REQ-018 Pop: a rising edge with m_valid=1 and m_ready=1 SHALL advance rd_ptr; m_ready while m_valid=0 SHALL be ignored.
REQ-019 m_valid SHALL equal (count!=0); m_data SHALL be mem[rd_ptr] and stable while m_valid=1 and m_ready=0.
REQ-020 Latency: a new_data pulse into an empty FIFO in cycle N SHALL give m_valid=1 with that sample in cycle N+1; there is no same-cycle bypass.
REQ-021 Pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-022 count SHALL be +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop (including at full and at empty-with-no-pop).
REQ-023 Push while count==DEPTH with no pop in the same cycle SHALL set overflow; the data handling is set by REQ-028/029.
REQ-024 overflow SHALL clear when clear_ovf=1, except that a same-cycle overflow event SHALL win and leave overflow=1.

Reset
REQ-025 rst=1 SHALL immediately and asynchronously set the divider to 0, the pointers to 0, count=0, overflow=0, read=0 and m_valid=0; m_data is don't-care.
REQ-026 Memory contents SHALL NOT be reset.
REQ-027 A reset asserted mid-stream SHALL discard all stored samples; the first push after release SHALL be the first sample popped.

Configuration
REQ-028 With MIC3_FIFO_DROP_OLDEST_EN defined, a push at full with no pop SHALL overwrite the oldest sample and advance rd_ptr and wr_ptr together, leaving count=DEPTH.
REQ-029 With MIC3_FIFO_DROP_OLDEST_EN undefined, a push at full with no pop SHALL discard the incoming sample, leaving the pointers, count and contents unchanged.

Verification
REQ-030 SAMPLE_DIV=32, enable=1 for 200 cycles: read pulses 32 cycles apart, each 1 cycle wide, first pulse at cycle 32 after enable rises; enable=0 mid-count gives no further pulses.
REQ-031 Push 0x001..0x005 with m_ready=0, then hold m_ready=1: count rises to 5, then the pops return 0x001..0x005 in order, m_valid falls after the 5th pop, and count=0.
REQ-032 DEPTH=16, push 0x100..0x110 (17 samples) with no pop: overflow=1 and count=16; without the macro the pops return 0x100..0x10F; with the macro they return 0x101..0x110.
REQ-033 FIFO full, then push 0xABC with m_ready=1 in the same cycle: count stays 16, overflow stays 0, and 0xABC is the last sample popped.
REQ-034 overflow=1 with clear_ovf=1 in the same cycle as an overflowing push: overflow stays 1; clear_ovf alone on the next cycle clears it.
REQ-035 Assert rst for one cycle with 7 samples stored: count=0 and m_valid=0 immediately; push 0x3FF after release, and the next pop returns 0x3FF.

Source files
------------

// File: rtl/mic3_sample_fifo.sv
// mic3_sample_fifo: periodic read-request generator for the MIC3 SPI
// interface plus a small sample FIFO with a ready/valid output side.
// Optional feature macro: MIC3_FIFO_DROP_OLDEST_EN
//   defined   -> a push into a full FIFO overwrites the oldest sample
//   undefined -> a push into a full FIFO discards the incoming sample
// Either way the sticky overflow flag records the event.
module mic3_sample_fifo #(
  parameter int DEPTH      = 16,
  parameter int SAMPLE_DIV = 2268
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  output logic                     read,
  input  logic [11:0]              audio_in,
  input  logic                     new_data,
  output logic [11:0]              m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clear_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [15:0]   DIV_LAST = 16'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [15:0]   div_cnt_r;
  logic [15:0]   div_nxt_s;
  logic          read_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          valid_r;
  logic          ovf_r;
  logic [11:0]   mem_r [DEPTH];

  logic push_s;
  logic pop_s;
  logic full_s;
  logic ovf_evt_s;
  logic wr_en_s;
  logic wr_adv_s;
  logic rd_adv_s;

  assign push_s = new_data;
  assign pop_s  = valid_r & m_ready;
  assign full_s = (cnt_r == FULL_CNT);

  // Next divider value: held at zero while disabled, wraps after DIV_LAST.
  always_comb begin
    div_nxt_s = 16'd0;
    if (!enable) begin
      div_nxt_s = 16'd0;
    end else if (div_cnt_r == DIV_LAST) begin
      div_nxt_s = 16'd0;
    end else begin
      div_nxt_s = div_cnt_r + 16'd1;
    end
  end

  // Divider state and registered read pulse, high exactly while the counter sits at DIV_LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_r <= 16'd0;
      read_r    <= 1'b0;
    end else begin
      div_cnt_r <= div_nxt_s;
      read_r    <= (div_nxt_s == DIV_LAST);
    end
  end

  // FIFO control: decide write, pointer moves and next occupancy for this cycle.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_adv_s  = 1'b0;
    rd_adv_s  = 1'b0;
    cnt_nxt_s = cnt_r;
    ovf_evt_s = 1'b0;
    if (push_s && !pop_s && full_s) begin
      ovf_evt_s = 1'b1;
`ifdef MIC3_FIFO_DROP_OLDEST_EN
      // Overwrite the oldest slot; both pointers move so occupancy stays full.
      wr_en_s  = 1'b1;
      wr_adv_s = 1'b1;
      rd_adv_s = 1'b1;
`else
      // Incoming sample is dropped; storage and pointers are untouched.
      wr_en_s  = 1'b0;
      wr_adv_s = 1'b0;
      rd_adv_s = 1'b0;
`endif
    end else begin
      wr_en_s  = push_s;
      wr_adv_s = push_s;
      rd_adv_s = pop_s;
      case ({push_s, pop_s})
        2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
        2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
        default: cnt_nxt_s = cnt_r;
      endcase
    end
  end

  // Pointer, occupancy, valid and sticky overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      valid_r  <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      if (wr_adv_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_adv_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      cnt_r   <= cnt_nxt_s;
      valid_r <= (cnt_nxt_s != '0);
      if (ovf_evt_s) begin
        ovf_r <= 1'b1;
      end else if (clear_ovf) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // Sample storage; deliberately not reset, stale contents are never visible.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= audio_in;
    end
  end

  assign read     = read_r;
  assign m_data   = mem_r[rd_ptr_r];
  assign m_valid  = valid_r;
  assign count    = cnt_r;
  assign overflow = ovf_r;

endmodule

// File: tb/tb_mic3_sample_fifo.sv
// Testbench for mic3_sample_fifo: directed scenarios plus a randomized run,
// all checked against a queue-based reference model of the FIFO.
module tb_mic3_sample_fifo;

  localparam int DEPTH = 16;
  localparam int DIV   = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        read;
  logic [11:0] audio_in = 12'h000;
  logic        new_data = 1'b0;
  logic [11:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [4:0]  count;
  logic        overflow;
  logic        clear_ovf = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: stored samples oldest-first, and the sticky flag.
  logic [11:0] q[$];
  logic        ovf_m = 1'b0;

  mic3_sample_fifo #(.DEPTH(DEPTH), .SAMPLE_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .enable(enable), .read(read),
    .audio_in(audio_in), .new_data(new_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .count(count), .overflow(overflow), .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  // One clock cycle: drive inputs, capture popped data, advance model. Called at a negedge.
  task automatic step(input logic nd, input logic [11:0] din, input logic rdy,
                      input logic clr, output logic popped,
                      output logic [11:0] exp_d, output logic [11:0] got_d);
    logic full;
    new_data  = nd;
    audio_in  = din;
    m_ready   = rdy;
    clear_ovf = clr;
    popped = (q.size() != 0) && rdy;
    exp_d  = popped ? q[0] : 12'h000;
    got_d  = popped ? m_data : 12'h000;
    full   = (q.size() == DEPTH);
    @(posedge clk);
    if (nd && !popped && full) begin
      ovf_m = 1'b1;
`ifdef MIC3_FIFO_DROP_OLDEST_EN
      void'(q.pop_front());
      q.push_back(din);
`endif
    end else begin
      if (popped) void'(q.pop_front());
      if (nd) q.push_back(din);
      if (clr) ovf_m = 1'b0;
    end
    @(negedge clk);
    new_data  = 1'b0;
    clear_ovf = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_cmp += 4;
    if (read !== 1'b0)     begin n_bad++; $display("FAIL reset_read got=%b want=0", read); end
    if (m_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_valid got=%b want=0", m_valid); end
    if (count !== 5'd0)    begin n_bad++; $display("FAIL reset_count got=%0d want=0", count); end
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_divider();
    int pulses = 0;
    enable = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      logic want;
      @(negedge clk);
      want = ((k % DIV) == DIV - 1);
      if (read === 1'b1) pulses++;
      n_cmp++;
      if (read !== want) begin n_bad++; $display("FAIL div_read cyc=%0d got=%b want=%b", k, read, want); end
    end
    enable = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      n_cmp++;
      if (read !== 1'b0) begin n_bad++; $display("FAIL div_off_read cyc=%0d got=%b want=0", k, read); end
    end
    n_cmp++;
    if (pulses != 6) begin n_bad++; $display("FAIL div_pulses got=%0d want=6", pulses); end
  endtask

  task automatic test_in_order();
    logic p; logic [11:0] e, g;
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 12'(i), 1'b0, 1'b0, p, e, g);
      n_cmp += 2;
      if (count !== 5'(i))  begin n_bad++; $display("FAIL order_count got=%0d want=%0d", count, i); end
      if (m_valid !== 1'b1) begin n_bad++; $display("FAIL order_valid got=%b want=1", m_valid); end
    end
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 12'h000, 1'b1, 1'b0, p, e, g);
      n_cmp += 2;
      if (g !== 12'(i)) begin n_bad++; $display("FAIL order_data got=%h want=%h", g, 12'(i)); end
      if (e !== 12'(i)) begin n_bad++; $display("FAIL order_model got=%h want=%h", e, 12'(i)); end
    end
    n_cmp += 2;
    if (m_valid !== 1'b0) begin n_bad++; $display("FAIL order_valid_end got=%b want=0", m_valid); end
    if (count !== 5'd0)   begin n_bad++; $display("FAIL order_count_end got=%0d want=0", count); end
    m_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic p; logic [11:0] e, g, want;
    for (int i = 0; i < 17; i++) step(1'b1, 12'h100 + 12'(i), 1'b0, 1'b0, p, e, g);
    n_cmp += 2;
    if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
    if (count !== 5'd16)   begin n_bad++; $display("FAIL ovf_count got=%0d want=16", count); end
    for (int i = 0; i < 16; i++) begin
`ifdef MIC3_FIFO_DROP_OLDEST_EN
      want = 12'h101 + 12'(i);
`else
      want = 12'h100 + 12'(i);
`endif
      step(1'b0, 12'h000, 1'b1, 1'b0, p, e, g);
      n_cmp++;
      if (g !== want) begin n_bad++; $display("FAIL ovf_data i=%0d got=%h want=%h", i, g, want); end
    end
    m_ready = 1'b0;
    step(1'b0, 12'h000, 1'b0, 1'b1, p, e, g);
    n_cmp++;
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic p; logic [11:0] e, g;
    for (int i = 0; i < 16; i++) step(1'b1, 12'h200 + 12'(i), 1'b0, 1'b0, p, e, g);
    step(1'b1, 12'hABC, 1'b1, 1'b0, p, e, g);
    n_cmp += 3;
    if (count !== 5'd16)   begin n_bad++; $display("FAIL fpp_count got=%0d want=16", count); end
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL fpp_ovf got=%b want=0", overflow); end
    if (g !== 12'h200)     begin n_bad++; $display("FAIL fpp_first got=%h want=200", g); end
    for (int i = 0; i < 16; i++) step(1'b0, 12'h000, 1'b1, 1'b0, p, e, g);
    n_cmp += 2;
    if (g !== 12'hABC)    begin n_bad++; $display("FAIL fpp_last got=%h want=abc", g); end
    if (m_valid !== 1'b0) begin n_bad++; $display("FAIL fpp_empty got=%b want=0", m_valid); end
    m_ready = 1'b0;
  endtask

  task automatic test_clear_race();
    logic p; logic [11:0] e, g;
    for (int i = 0; i < 17; i++) step(1'b1, 12'h300 + 12'(i), 1'b0, 1'b0, p, e, g);
    step(1'b1, 12'h3EE, 1'b0, 1'b1, p, e, g);
    n_cmp++;
    if (overflow !== 1'b1) begin n_bad++; $display("FAIL race_ovf got=%b want=1", overflow); end
    step(1'b0, 12'h000, 1'b0, 1'b1, p, e, g);
    n_cmp += 2;
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL race_clear got=%b want=0", overflow); end
    if (count !== 5'd16)   begin n_bad++; $display("FAIL race_count got=%0d want=16", count); end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 12'h000, 1'b1, 1'b0, p, e, g);
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL race_data got=%h want=%h", g, e); end
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    logic p; logic [11:0] e, g;
    for (int i = 0; i < 7; i++) step(1'b1, 12'h050 + 12'(i), 1'b0, 1'b0, p, e, g);
    #2 rst = 1'b1;
    #1;
    n_cmp += 2;
    if (count !== 5'd0)   begin n_bad++; $display("FAIL mrst_count got=%0d want=0", count); end
    if (m_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_valid got=%b want=0", m_valid); end
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    ovf_m = 1'b0;
    step(1'b1, 12'h3FF, 1'b0, 1'b0, p, e, g);
    step(1'b0, 12'h000, 1'b1, 1'b0, p, e, g);
    n_cmp += 2;
    if (p !== 1'b1)    begin n_bad++; $display("FAIL mrst_pop got=%b want=1", p); end
    if (g !== 12'h3FF) begin n_bad++; $display("FAIL mrst_data got=%h want=3ff", g); end
    m_ready = 1'b0;
  endtask

  task automatic test_random();
    logic p; logic [11:0] e, g;
    for (int c = 0; c < 3000; c++) begin
      int phase = (c / 150) % 2;
      logic nd  = ($urandom_range(0, 99) < (phase == 0 ? 70 : 30));
      logic rdy = ($urandom_range(0, 99) < (phase == 0 ? 30 : 70));
      logic clr = ($urandom_range(0, 99) < 5);
      step(nd, 12'($urandom), rdy, clr, p, e, g);
      n_cmp += 4;
      if (p && g !== e) begin n_bad++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", c, g, e); end
      if (count !== 5'(q.size())) begin n_bad++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", c, count, q.size()); end
      if (m_valid !== (q.size() != 0)) begin n_bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", c, m_valid, q.size() != 0); end
      if (overflow !== ovf_m) begin n_bad++; $display("FAIL rnd_ovf cyc=%0d got=%b want=%b", c, overflow, ovf_m); end
    end
    m_ready = 1'b0;
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_divider();
    test_in_order();
    test_overflow();
    test_full_push_pop();
    test_clear_race();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
